// File: rtl/spsram_arb_pkg.sv
// Shared definitions for the two-port spsram front end.
package spsram_arb_pkg;

  // FSM state encoding: zero-fill after reset, then normal arbitration.
  localparam logic INIT = 1'b0;
  localparam logic RUN  = 1'b1;

  // Requester index: two requesters need one bit.
  localparam int IDX_W = 1;
  typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The grant is combinational from valid and the
// pointer. The pointer moves to the losing side after every grant.
module rr_arb2
  import spsram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  idx_t rr_ptr;

  // Grant a lone requester outright; on a tie, grant the side rr_ptr names.
  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (rr_ptr == idx_t'(1)) ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  // After a grant, point at the other requester so it wins the next tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (|grant) begin
      rr_ptr <= idx_t'(grant[0]);
    end
  end

endmodule

// File: rtl/spsram_arb.sv
// Front end for one spsram macro: zero-fills the array after reset, then
// arbitrates two requesters onto the single SRAM port, one access per cycle.
//
// Handshake: a command transfers on a rising clock edge when
// i_reqN_valid & o_reqN_ready are both high; ready is combinational from the
// valids and is only ever high for one requester per cycle. Read responses
// are a single-cycle o_rspN_valid pulse two edges after the accept edge and
// cannot be back-pressured.
module spsram_arb
  import spsram_arb_pkg::*;
#(
  parameter int BW_DATA = 32,
  parameter int BW_ADDR = 5
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_req0_valid,
  output logic               o_req0_ready,
  input  logic               i_req0_wen,
  input  logic [BW_ADDR-1:0] i_req0_addr,
  input  logic [BW_DATA-1:0] i_req0_data,
  output logic               o_rsp0_valid,
  output logic [BW_DATA-1:0] o_rsp0_data,
  input  logic               i_req1_valid,
  output logic               o_req1_ready,
  input  logic               i_req1_wen,
  input  logic [BW_ADDR-1:0] i_req1_addr,
  input  logic [BW_DATA-1:0] i_req1_data,
  output logic               o_rsp1_valid,
  output logic [BW_DATA-1:0] o_rsp1_data,
  output logic               o_init_done,
  output logic               o_mem_cen,
  output logic               o_mem_wen,
  output logic               o_mem_oen,
  output logic [BW_ADDR-1:0] o_mem_addr,
  output logic [BW_DATA-1:0] o_mem_data,
  input  logic [BW_DATA-1:0] i_mem_data,
  output logic               o_dbg_state
);

  logic               state;
  logic [BW_ADDR-1:0] init_cnt;
  logic [1:0]         grant;

  // Selected command (requester 1 when it holds the grant, else requester 0).
  logic               sel_wen;
  logic [BW_ADDR-1:0] sel_addr;
  logic [BW_DATA-1:0] sel_data;

  // S1 carries the owner of the access the SRAM performs next edge;
  // pipe_* carries it for the cycle the SRAM read data is in flight.
  logic s1_rd;
  idx_t s1_tag;
  logic pipe_rd;
  idx_t pipe_tag;

  rr_arb2 u_rr_arb2 (
    .clk   (i_clk),
    .rst   (i_rst),
    .en    (state == RUN),
    .valid ({i_req1_valid, i_req0_valid}),
    .grant (grant)
  );

  assign o_req0_ready = grant[0];
  assign o_req1_ready = grant[1];
  assign o_dbg_state  = state;

  // Mux the granted requester's command onto the SRAM drive path.
  always_comb begin
    sel_wen  = i_req0_wen;
    sel_addr = i_req0_addr;
    sel_data = i_req0_data;
    if (grant[1]) begin
      sel_wen  = i_req1_wen;
      sel_addr = i_req1_addr;
      sel_data = i_req1_data;
    end
  end

  // FSM and S1: zero-fill writes during INIT, granted commands during RUN.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= INIT;
      init_cnt    <= '0;
      o_init_done <= 1'b0;
      o_mem_cen   <= 1'b0;
      o_mem_wen   <= 1'b0;
      o_mem_oen   <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_data  <= '0;
      s1_rd       <= 1'b0;
      s1_tag      <= '0;
    end else begin
      case (state)
        INIT: begin
          o_mem_cen  <= 1'b1;
          o_mem_wen  <= 1'b1;
          o_mem_oen  <= 1'b0;
          o_mem_addr <= init_cnt;
          o_mem_data <= '0;
          s1_rd      <= 1'b0;
          init_cnt   <= init_cnt + 1'b1;
          // The last fill write goes out on this edge; RUN is terminal.
          if (init_cnt == '1) begin
            state       <= RUN;
            o_init_done <= 1'b1;
          end
        end
        default: begin
          if (|grant) begin
            o_mem_cen  <= 1'b1;
            o_mem_wen  <= sel_wen;
            o_mem_oen  <= ~sel_wen;
            o_mem_addr <= sel_addr;
            o_mem_data <= sel_data;
            s1_rd      <= ~sel_wen;
            s1_tag     <= idx_t'(grant[1]);
          end else begin
            o_mem_cen <= 1'b0;
            o_mem_wen <= 1'b0;
            o_mem_oen <= 1'b0;
            s1_rd     <= 1'b0;
          end
        end
      endcase
    end
  end

  // S2: follow the read through the SRAM cycle and steer data to its owner.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pipe_rd      <= 1'b0;
      pipe_tag     <= '0;
      o_rsp0_valid <= 1'b0;
      o_rsp1_valid <= 1'b0;
      o_rsp0_data  <= '0;
      o_rsp1_data  <= '0;
    end else begin
      pipe_rd      <= s1_rd;
      pipe_tag     <= s1_tag;
      o_rsp0_valid <= pipe_rd & (pipe_tag == idx_t'(0));
      o_rsp1_valid <= pipe_rd & (pipe_tag == idx_t'(1));
      if (pipe_rd && pipe_tag == idx_t'(0)) o_rsp0_data <= i_mem_data;
      if (pipe_rd && pipe_tag == idx_t'(1)) o_rsp1_data <= i_mem_data;
    end
  end

endmodule

// File: tb/tb_spsram_arb.sv
// Bench for spsram_arb with a behavioural SRAM behind it. A reference model
// (array memory, per-port expected-data queues and a two-deep timing line)
// predicts ready, init_done and every response each cycle.
module tb_spsram_arb;

  localparam int BW_DATA = 32;
  localparam int BW_ADDR = 5;
  localparam int DEPTH   = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic               req0_valid, req0_ready, req0_wen;
  logic [BW_ADDR-1:0] req0_addr;
  logic [BW_DATA-1:0] req0_data;
  logic               rsp0_valid;
  logic [BW_DATA-1:0] rsp0_data;
  logic               req1_valid, req1_ready, req1_wen;
  logic [BW_ADDR-1:0] req1_addr;
  logic [BW_DATA-1:0] req1_data;
  logic               rsp1_valid;
  logic [BW_DATA-1:0] rsp1_data;
  logic               init_done;
  logic               mem_cen, mem_wen, mem_oen;
  logic [BW_ADDR-1:0] mem_addr;
  logic [BW_DATA-1:0] mem_wdata, mem_rdata;
  logic               dbg_state;

  spsram_arb #(.BW_DATA(BW_DATA), .BW_ADDR(BW_ADDR)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req0_valid (req0_valid),
    .o_req0_ready (req0_ready),
    .i_req0_wen   (req0_wen),
    .i_req0_addr  (req0_addr),
    .i_req0_data  (req0_data),
    .o_rsp0_valid (rsp0_valid),
    .o_rsp0_data  (rsp0_data),
    .i_req1_valid (req1_valid),
    .o_req1_ready (req1_ready),
    .i_req1_wen   (req1_wen),
    .i_req1_addr  (req1_addr),
    .i_req1_data  (req1_data),
    .o_rsp1_valid (rsp1_valid),
    .o_rsp1_data  (rsp1_data),
    .o_init_done  (init_done),
    .o_mem_cen    (mem_cen),
    .o_mem_wen    (mem_wen),
    .o_mem_oen    (mem_oen),
    .o_mem_addr   (mem_addr),
    .o_mem_data   (mem_wdata),
    .i_mem_data   (mem_rdata),
    .o_dbg_state  (dbg_state)
  );

  // Behavioural single-port SRAM: read data appears after the read edge.
  logic [BW_DATA-1:0] sram [DEPTH];
  always @(posedge clk) begin
    if (mem_cen) begin
      if (mem_wen) sram[mem_addr] <= mem_wdata;
      else if (mem_oen) mem_rdata <= sram[mem_addr];
    end
  end

  // ---------------- reference model / scoreboard ----------------
  int checks = 0;
  int errors = 0;

  logic [BW_DATA-1:0] ref_mem [DEPTH];
  logic [BW_DATA-1:0] exp_q0[$];
  logic [BW_DATA-1:0] exp_q1[$];
  logic               run_m;
  int                 init_k;
  logic               rr_m;
  logic               line_v[2];
  logic               line_p[2];
  logic               ev0, ev1;
  logic [BW_DATA-1:0] last0, last1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    run_m  = 1'b0;
    init_k = 0;
    rr_m   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      line_v[i] = 1'b0;
      line_p[i] = 1'b0;
    end
    ev0 = 1'b0;
    ev1 = 1'b0;
    last0 = '0;
    last1 = '0;
    exp_q0.delete();
    exp_q1.delete();
    // The zero-fill always completes before any access can be granted.
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    req0_valid = 1'b0; req0_wen = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_wen = 1'b0; req1_addr = '0; req1_data = '0;
  endtask

  // Called at a negedge; holds reset across one posedge, checks cleared outputs.
  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("rst_mem_cen", {31'd0, mem_cen}, 32'd0);
    chk("rst_mem_wen", {31'd0, mem_wen}, 32'd0);
    chk("rst_mem_oen", {31'd0, mem_oen}, 32'd0);
    chk("rst_mem_addr", {27'd0, mem_addr}, 32'd0);
    chk("rst_mem_data", mem_wdata, 32'd0);
    chk("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    chk("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    chk("rst_rsp0_data", rsp0_data, 32'd0);
    chk("rst_rsp1_data", rsp1_data, 32'd0);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    chk("rst_state", {31'd0, dbg_state}, 32'd0);
  endtask

  // One clock: drive at negedge, check against the model, advance at posedge.
  task automatic cycle(input logic v0, input logic w0, input logic [BW_ADDR-1:0] a0,
                       input logic [BW_DATA-1:0] d0,
                       input logic v1, input logic w1, input logic [BW_ADDR-1:0] a1,
                       input logic [BW_DATA-1:0] d1,
                       output logic r0, output logic r1);
    logic g0, g1, nv;
    req0_valid = v0; req0_wen = w0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_wen = w1; req1_addr = a1; req1_data = d1;
    #1;
    g0 = 1'b0;
    g1 = 1'b0;
    if (run_m) begin
      if (v0 && v1) begin
        g0 = ~rr_m;
        g1 = rr_m;
      end else begin
        g0 = v0;
        g1 = v1;
      end
    end
    r0 = req0_ready;
    r1 = req1_ready;
    chk("ready0", {31'd0, r0}, {31'd0, g0});
    chk("ready1", {31'd0, r1}, {31'd0, g1});
    chk("init_done", {31'd0, init_done}, {31'd0, run_m});
    chk("state", {31'd0, dbg_state}, {31'd0, run_m});
    if (!run_m && init_k > 0) begin
      chk("init_cen", {31'd0, mem_cen}, 32'd1);
      chk("init_wen", {31'd0, mem_wen}, 32'd1);
      chk("init_addr", {27'd0, mem_addr}, 32'(init_k - 1));
      chk("init_data", mem_wdata, 32'd0);
    end
    chk("rsp0_valid", {31'd0, rsp0_valid}, {31'd0, ev0});
    chk("rsp1_valid", {31'd0, rsp1_valid}, {31'd0, ev1});
    chk("rsp0_data", rsp0_data, last0);
    chk("rsp1_data", rsp1_data, last1);
    @(posedge clk);
    nv = 1'b0;
    if (g0) begin
      if (w0) ref_mem[a0] = d0;
      else begin exp_q0.push_back(ref_mem[a0]); nv = 1'b1; end
      rr_m = 1'b1;
    end
    if (g1) begin
      if (w1) ref_mem[a1] = d1;
      else begin exp_q1.push_back(ref_mem[a1]); nv = 1'b1; end
      rr_m = 1'b0;
    end
    ev0 = line_v[1] && !line_p[1];
    ev1 = line_v[1] && line_p[1];
    if (ev0 && exp_q0.size() > 0) last0 = exp_q0.pop_front();
    if (ev1 && exp_q1.size() > 0) last1 = exp_q1.pop_front();
    line_v[1] = line_v[0];
    line_p[1] = line_p[0];
    line_v[0] = nv;
    line_p[0] = g1;
    if (!run_m) begin
      init_k++;
      if (init_k == DEPTH) run_m = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic r0, r1;
    for (int i = 0; i < n; i++) cycle(0, 0, '0, '0, 0, 0, '0, '0, r0, r1);
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic v0; logic w0; logic [BW_ADDR-1:0] a0; logic [BW_DATA-1:0] d0;
    logic v1; logic w1; logic [BW_ADDR-1:0] a1; logic [BW_DATA-1:0] d1;
    logic r0; logic r1;
  } vec_t;
  vec_t vecs[10];

  // ---------------- test sequence ----------------
  initial begin
    logic r0, r1;
    int   waited;

    vecs[0] = '{1, 1, 5'd3, 32'h33,       0, 0, 5'd0, 32'h0,        1, 0};
    vecs[1] = '{0, 0, 5'd0, 32'h0,        1, 1, 5'd4, 32'h44,       0, 1};
    vecs[2] = '{1, 0, 5'd3, 32'h0,        1, 0, 5'd4, 32'h0,        1, 0};
    vecs[3] = '{1, 0, 5'd3, 32'h0,        1, 0, 5'd4, 32'h0,        0, 1};
    vecs[4] = '{1, 0, 5'd3, 32'h0,        1, 0, 5'd4, 32'h0,        1, 0};
    vecs[5] = '{1, 0, 5'd3, 32'h0,        1, 0, 5'd4, 32'h0,        0, 1};
    vecs[6] = '{0, 0, 5'd0, 32'h0,        1, 1, 5'd7, 32'hDEADBEEF, 0, 1};
    vecs[7] = '{1, 0, 5'd7, 32'h0,        0, 0, 5'd0, 32'h0,        1, 0};
    vecs[8] = '{0, 0, 5'd0, 32'h0,        0, 0, 5'd0, 32'h0,        0, 0};
    vecs[9] = '{0, 0, 5'd0, 32'h0,        0, 0, 5'd0, 32'h0,        0, 0};

    for (int i = 0; i < DEPTH; i++) sram[i] = $urandom;
    mem_rdata = '0;
    drive_idle();
    @(negedge clk);

    // Zero-fill, then every address reads back zero.
    do_reset();
    idle(DEPTH);
    chk("init_done_after_32", {31'd0, init_done}, 32'd1);
    for (int i = 0; i < DEPTH; i++) cycle(1, 0, 5'(i), '0, 0, 0, '0, '0, r0, r1);
    idle(3);

    // Requester 0 alone: write i <- i, then stream reads back.
    for (int i = 0; i < DEPTH; i++) cycle(1, 1, 5'(i), 32'(i), 0, 0, '0, '0, r0, r1);
    for (int i = 0; i < DEPTH; i++) cycle(1, 0, 5'(i), '0, 0, 0, '0, '0, r0, r1);
    idle(3);

    // Reset mid-INIT at cycle 10 restarts the fill.
    do_reset();
    idle(10);
    do_reset();
    idle(DEPTH - 1);
    chk("init_not_done_31", {31'd0, init_done}, 32'd0);
    idle(1);
    chk("init_done_32", {31'd0, init_done}, 32'd1);

    // Table: ties alternate from rr=0, write-then-read forwarding.
    for (int i = 0; i < 10; i++) begin
      cycle(vecs[i].v0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
            vecs[i].v1, vecs[i].w1, vecs[i].a1, vecs[i].d1, r0, r1);
      chk($sformatf("vec%0d_ready0", i), {31'd0, r0}, {31'd0, vecs[i].r0});
      chk($sformatf("vec%0d_ready1", i), {31'd0, r1}, {31'd0, vecs[i].r1});
    end
    chk("fwd_rsp0_data", rsp0_data, 32'hDEADBEEF);

    // Requester 1 holds a write while requester 0 streams reads.
    cycle(1, 0, 5'd1, '0, 0, 0, '0, '0, r0, r1);
    waited = 0;
    r1 = 1'b0;
    while (!r1 && waited < 4) begin
      cycle(1, 0, 5'(waited + 2), '0, 1, 1, 5'd9, 32'hA5A50009, r0, r1);
      waited++;
    end
    chk("req1_no_starve", {31'd0, (r1 && waited <= 2)}, 32'd1);
    for (int i = 0; i < 3; i++) cycle(1, 0, 5'(i + 10), '0, 0, 0, '0, '0, r0, r1);
    cycle(1, 0, 5'd9, '0, 0, 0, '0, '0, r0, r1);
    idle(3);
    chk("held_cmd_data", rsp0_data, 32'hA5A50009);

    // Reset during RUN with a read one edge and two edges into the pipe.
    cycle(1, 0, 5'd9, '0, 0, 0, '0, '0, r0, r1);
    do_reset();
    idle(DEPTH + 3);
    cycle(0, 0, '0, '0, 1, 0, 5'd9, '0, r0, r1);
    idle(1);
    do_reset();
    idle(DEPTH + 3);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, DEPTH - 1)), $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, DEPTH - 1)), $urandom, r0, r1);
    end
    idle(3);
    chk("exp_q0_drained", 32'(exp_q0.size()), 32'd0);
    chk("exp_q1_drained", 32'(exp_q1.size()), 32'd0);

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
